// File: rtl/bpu_ctrl.sv
// Branch-prediction controller: BTB lookup and next-PC prediction in IF, prediction
// tracking through ID/EX, mispredict redirect and BTB install in EX. Optional macro: BPU_2BIT_COUNTER_EN.
module bpu_ctrl (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_if_pc,
  input  logic        i_if_valid,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_ex_is_br,
  input  logic        i_ex_taken,
  input  logic [31:0] i_ex_target,
  output logic [9:0]  o_btb_rd_addr,
  input  logic [19:0] i_btb_tag,
  input  logic [31:0] i_btb_pred_pc,
  input  logic        i_btb_valid,
  output logic [9:0]  o_btb_wr_addr,
  output logic [19:0] o_btb_tag,
  output logic [31:0] o_btb_pred_pc,
  output logic        o_btb_wren,
  output logic        o_pred_taken,
  output logic [31:0] o_next_pc,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc
);

  logic        hit;
  logic        dir;
  logic        pred_taken;

  // Stage handshake: a stage's valid bit marks a real instruction; the stage
  // captures from upstream on every edge where i_stall is low and holds otherwise.
  // Redirect or i_flush clears both valid bits at the edge, regardless of i_stall.
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_pred_taken_q, id_pred_taken_d;
  logic [31:0] id_pred_pc_q, id_pred_pc_d;
  logic        id_hit_q, id_hit_d;

  logic        ex_valid_q, ex_valid_d;
  logic [31:0] ex_pc_q, ex_pc_d;
  logic        ex_pred_taken_q, ex_pred_taken_d;
  logic [31:0] ex_pred_pc_q, ex_pred_pc_d;
  logic        ex_hit_q, ex_hit_d;

  logic        resolve;
  logic        actual_taken;
  logic        target_diff;
  logic        mispredict;
  logic        btb_wren;

  assign o_btb_rd_addr = i_if_pc[11:2];
  assign hit           = i_btb_valid & (i_btb_tag == i_if_pc[31:12]);

`ifdef BPU_2BIT_COUNTER_EN
  logic [1:0] ctr_q [64];
  logic [1:0] ctr_d [64];
  logic [5:0] ctr_idx;

  assign dir = ctr_q[i_if_pc[7:2]][1];
`else
  assign dir = 1'b1;
`endif

  assign pred_taken   = hit & dir;
  assign o_pred_taken = pred_taken;
  assign o_next_pc    = pred_taken ? i_btb_pred_pc : i_if_pc + 32'd4;

  // Resolution is suppressed while stalled or in reset so each EX instruction fires once.
  assign resolve      = i_rst_n & ex_valid_q & ~i_stall;
  assign actual_taken = i_ex_is_br & i_ex_taken;
  assign target_diff  = ex_pred_pc_q != i_ex_target;
  assign mispredict   = resolve & ((ex_pred_taken_q & ~actual_taken) |
                                   (actual_taken & (~ex_pred_taken_q | target_diff)));
  assign btb_wren     = resolve & actual_taken & (~ex_hit_q | target_diff);

  assign o_redirect    = mispredict;
  assign o_redirect_pc = actual_taken ? i_ex_target : ex_pc_q + 32'd4;
  assign o_btb_wren    = btb_wren;
  assign o_btb_wr_addr = ex_pc_q[11:2];
  assign o_btb_tag     = ex_pc_q[31:12];
  assign o_btb_pred_pc = i_ex_target;

  // pred_pc keeps the raw BTB target even when predicted not-taken, so an
  // unchanged target on a hit does not trigger a needless rewrite.
  always_comb begin
    id_valid_d      = id_valid_q;
    id_pc_d         = id_pc_q;
    id_pred_taken_d = id_pred_taken_q;
    id_pred_pc_d    = id_pred_pc_q;
    id_hit_d        = id_hit_q;
    ex_valid_d      = ex_valid_q;
    ex_pc_d         = ex_pc_q;
    ex_pred_taken_d = ex_pred_taken_q;
    ex_pred_pc_d    = ex_pred_pc_q;
    ex_hit_d        = ex_hit_q;
    if (!i_stall) begin
      id_valid_d      = i_if_valid;
      id_pc_d         = i_if_pc;
      id_pred_taken_d = pred_taken;
      id_pred_pc_d    = i_btb_pred_pc;
      id_hit_d        = hit;
      ex_valid_d      = id_valid_q;
      ex_pc_d         = id_pc_q;
      ex_pred_taken_d = id_pred_taken_q;
      ex_pred_pc_d    = id_pred_pc_q;
      ex_hit_d        = id_hit_q;
    end
    if (mispredict | i_flush) begin
      id_valid_d = 1'b0;
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      id_valid_q      <= 1'b0;
      id_pc_q         <= 32'd0;
      id_pred_taken_q <= 1'b0;
      id_pred_pc_q    <= 32'd0;
      id_hit_q        <= 1'b0;
      ex_valid_q      <= 1'b0;
      ex_pc_q         <= 32'd0;
      ex_pred_taken_q <= 1'b0;
      ex_pred_pc_q    <= 32'd0;
      ex_hit_q        <= 1'b0;
    end else begin
      id_valid_q      <= id_valid_d;
      id_pc_q         <= id_pc_d;
      id_pred_taken_q <= id_pred_taken_d;
      id_pred_pc_q    <= id_pred_pc_d;
      id_hit_q        <= id_hit_d;
      ex_valid_q      <= ex_valid_d;
      ex_pc_q         <= ex_pc_d;
      ex_pred_taken_q <= ex_pred_taken_d;
      ex_pred_pc_q    <= ex_pred_pc_d;
      ex_hit_q        <= ex_hit_d;
    end
  end

`ifdef BPU_2BIT_COUNTER_EN
  // A fresh install restarts its counter at weakly-taken, overriding the increment.
  always_comb begin
    for (int i = 0; i < 64; i++) begin
      ctr_d[i] = ctr_q[i];
    end
    ctr_idx = ex_pc_q[7:2];
    if (btb_wren) begin
      ctr_d[ctr_idx] = 2'b10;
    end else if (resolve & i_ex_is_br) begin
      if (i_ex_taken) begin
        ctr_d[ctr_idx] = (ctr_q[ctr_idx] == 2'b11) ? 2'b11 : ctr_q[ctr_idx] + 2'd1;
      end else begin
        ctr_d[ctr_idx] = (ctr_q[ctr_idx] == 2'b00) ? 2'b00 : ctr_q[ctr_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 64; i++) begin
        ctr_q[i] <= 2'b10;
      end
    end else begin
      for (int i = 0; i < 64; i++) begin
        ctr_q[i] <= ctr_d[i];
      end
    end
  end
`endif

endmodule

// File: doc/bpu_ctrl.md
# bpu_ctrl

Branch-prediction controller that drives the BTB storage array from both ends. In IF it issues the BTB lookup for the fetch PC, checks the tag and produces the predicted next PC. It carries each prediction through ID into EX, compares it against the resolved branch outcome, raises a redirect/flush on mispredict, and issues the BTB write that installs or corrects an entry.

## Interface
- No parameters. Index is pc[11:2] (1024 entries), tag is pc[31:12], counter index is pc[7:2].
- i_clk  in  1  clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_if_pc  in  32  fetch PC
- i_if_valid  in  1  fetch slot holds a real instruction
- i_stall  in  1  hold IF/ID and ID/EX prediction registers
- i_flush  in  1  external flush (trap); clears ID and EX valid
- i_ex_is_br  in  1  EX instruction is branch/jal/jalr
- i_ex_taken  in  1  resolved direction
- i_ex_target  in  32  resolved target
- o_btb_rd_addr  out  10  i_if_pc[11:2]
- i_btb_tag  in  20  BTB read tag
- i_btb_pred_pc  in  32  BTB read target
- i_btb_valid  in  1  BTB read valid
- o_btb_wr_addr  out  10  write index
- o_btb_tag  out  20  write tag
- o_btb_pred_pc  out  32  write target
- o_btb_wren  out  1  write strobe, one cycle
- o_pred_taken  out  1  IF prediction
- o_next_pc  out  32  IF next PC
- o_redirect  out  1  mispredict redirect
- o_redirect_pc  out  32  corrected PC

## Operation
- Hit = i_btb_valid & (i_btb_tag == i_if_pc[31:12]). o_pred_taken = hit & dir; o_next_pc = o_pred_taken ? i_btb_pred_pc : i_if_pc+4. All combinational.
- Pipeline regs per stage (ID, EX): valid, pc, pred_taken, pred_pc, hit. Advance on each edge when !i_stall.
- EX resolution (only when ex_valid & !i_stall):
  - mispredict = (pred_taken & !(is_br & taken)) | (is_br & taken & (!pred_taken | pred_pc != target)).
  - o_redirect = mispredict; o_redirect_pc = (is_br & taken) ? target : ex_pc+4.
  - o_btb_wren = is_br & taken & (!hit | pred_pc != target); address ex_pc[11:2], tag ex_pc[31:12], data target.
- On o_redirect or i_flush at an edge: ID.valid and EX.valid become 0, even if i_stall is high (flush wins over stall).
- Not-taken branches never invalidate the BTB entry.
- Reset: all valid bits 0; o_redirect, o_btb_wren 0; counters (if enabled) 2'b10.

## Timing
- Lookup to prediction: 0 cycles (same cycle as i_if_pc).
- Prediction reaches EX two edges after IF (absent stall).
- o_redirect and o_btb_wren are combinational from EX regs, asserted for exactly one cycle per resolved instruction. They are gated low while i_stall is high, so a stalled EX instruction fires once, on the cycle it leaves EX.
- BTB write lands at the next edge; a lookup of the same index in that cycle sees old data.
- Reset mid-operation clears in-flight predictions at the reset edge. Nothing issues in the cycle after reset.

## Configuration
- BPU_2BIT_COUNTER_EN defined: adds a 64-entry table of 2-bit saturating counters indexed by pc[7:2].
  - dir = ctr[1].
  - For each resolved is_br in EX (same gating as redirect), the counter at ex_pc[7:2] increments if taken and decrements if not, saturating at 3/0.
  - A counter is set to 2'b10 when o_btb_wren fires for its index.
- Undefined: no counter table; dir = 1 (any BTB hit predicts taken).

## Test plan
- Cold BTB, taken branch at 0x0000_1000, target 0x0000_2000: o_redirect=1 with o_redirect_pc=0x2000; o_btb_wren=1 with wr_addr=0x000, tag=0x00001, data 0x2000. Refetching 0x1000 gives o_next_pc=0x2000.
- BTB hit predicting 0x2000, EX resolves not taken: o_redirect_pc=0x1004, no write. With macro, the counter goes 2→1, and the next fetch of 0x1000 gives o_next_pc=0x1004.
- Hit with stale target 0x2000, resolved target 0x3000: redirect to 0x3000; write updates data to 0x3000.
- Tag alias: entry for 0x0000_1000, fetch 0x0000_5000 (same index, tag 0x5): no hit, o_next_pc=0x5004.
- Mispredict in EX with i_stall=1 for 3 cycles: o_redirect stays 0 while stalled and pulses once on release. ID/EX valid bits are cleared on that edge.
- Assert i_rst_n=0 while a mispredicting branch is in EX: no redirect or write that cycle or after. All valids are 0 after reset.
